// File: rtl/uart_echo_fifo.sv
// -----------------------------------------------------------------------------
// uart_echo_fifo
//   Buffering echo engine placed between the UART receiver's byte strobe and
//   the UART transmitter's load strobe. Received bytes queue in a FIFO while
//   the transmitter is busy. Each byte is echoed raw, folded to uppercase, or
//   sent as two ASCII hex characters, depending on MODE. The block also keeps a
//   last-byte register for the display, a received-byte counter, fill status
//   and a sticky overflow flag.
//
// Parameters
//   DEPTH   FIFO entries (power of two, 2..256)
//   ADDR_W  log2(DEPTH)
//   MODE    0 = raw echo, 1 = a-z folded to A-Z, 2 = two hex characters
//   CNT_W   width of the received-byte counter
//
// Ports
//   i_clk            system clock, rising edge
//   i_reset          asynchronous active-low reset
//   i_rx_data_ready  one-cycle strobe: i_rx_data valid
//   i_rx_data        received byte
//   i_tx_done        one-cycle strobe: transmitter finished current character
//   i_clr_ovf        synchronous clear of o_overflow
//   o_tx_data_ready  one-cycle load strobe to the transmitter
//   o_tx_data        character for the transmitter, held between strobes
//   o_last_byte      last byte accepted into the FIFO
//   o_count          bytes accepted since reset (wraps)
//   o_fill           FIFO occupancy 0..DEPTH
//   o_empty          o_fill == 0
//   o_full           o_fill == DEPTH
//   o_overflow       sticky: a byte was dropped because the FIFO was full
// -----------------------------------------------------------------------------
module uart_echo_fifo #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned MODE   = 0,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_rx_data_ready,
  input  logic [7:0]        i_rx_data,
  input  logic              i_tx_done,
  input  logic              i_clr_ovf,
  output logic              o_tx_data_ready,
  output logic [7:0]        o_tx_data,
  output logic [7:0]        o_last_byte,
  output logic [CNT_W-1:0]  o_count,
  output logic [ADDR_W:0]   o_fill,
  output logic              o_empty,
  output logic              o_full,
  output logic              o_overflow
);

  localparam logic [ADDR_W:0] FULL_FILL = (ADDR_W+1)'(DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT,
    ST_SEND_LO,
    ST_WAIT_LO
  } state_e;

  // ---------------------------------------------------------------------------
  // Storage and status registers
  // ---------------------------------------------------------------------------
  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W-1:0] rd_ptr_q;
  logic [ADDR_W:0]   fill_q;
  logic [ADDR_W:0]   fill_d;
  logic              empty_q;
  logic              full_q;
  logic [7:0]        last_q;
  logic [CNT_W-1:0]  count_q;
  logic              ovf_q;

  state_e            state_q;
  logic [7:0]        hold_q;
  logic              tx_rdy_q;
  logic [7:0]        tx_data_q;

  logic              pop;
  logic              push;
  logic              drop;
  logic [7:0]        head;

  // ---------------------------------------------------------------------------
  // Character transforms
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] hex_char(input logic [3:0] n);
    logic [7:0] r;
    if (n <= 4'd9) r = 8'h30 + {4'h0, n};
    else           r = 8'h37 + {4'h0, n};
    return r;
  endfunction

  function automatic logic [7:0] first_char(input logic [7:0] b);
    logic [7:0] r;
    r = b;
    if (MODE == 1) begin
      if (b >= 8'h61 && b <= 8'h7A) r = b - 8'h20;
    end else if (MODE == 2) begin
      r = hex_char(b[7:4]);
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Push / pop decisions
  // ---------------------------------------------------------------------------
  // A pop frees a slot on the same edge, so a full FIFO still accepts a byte
  // when the FSM is taking the head at that moment.
  always_comb begin
    pop  = (state_q == ST_IDLE) && !empty_q;
    push = i_rx_data_ready && (!full_q || pop);
    drop = i_rx_data_ready && !push;
    head = mem_q[rd_ptr_q];
  end

  always_comb begin
    fill_d = fill_q;
    case ({push, pop})
      2'b10:   fill_d = fill_q + (ADDR_W+1)'(1);
      2'b01:   fill_d = fill_q - (ADDR_W+1)'(1);
      default: fill_d = fill_q;
    endcase
  end

  // FIFO storage carries no reset; only the pointers define validity.
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= i_rx_data;
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      last_q   <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      fill_q  <= fill_d;
      empty_q <= (fill_d == '0);
      full_q  <= (fill_d == FULL_FILL);
      if (push) begin
        wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
        last_q   <= i_rx_data;
        count_q  <= count_q + CNT_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
      // Setting takes priority over a coincident clear.
      if (drop)           ovf_q <= 1'b1;
      else if (i_clr_ovf) ovf_q <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Transmit FSM with registered strobe and character
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q   <= ST_IDLE;
      hold_q    <= '0;
      tx_rdy_q  <= 1'b0;
      tx_data_q <= '0;
    end else begin
      tx_rdy_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pop) begin
            hold_q  <= head;
            state_q <= ST_SEND;
          end
        end
        ST_SEND: begin
          tx_rdy_q  <= 1'b1;
          tx_data_q <= first_char(hold_q);
          state_q   <= ST_WAIT;
        end
        ST_WAIT: begin
          if (i_tx_done) state_q <= (MODE == 2) ? ST_SEND_LO : ST_IDLE;
        end
        ST_SEND_LO: begin
          tx_rdy_q  <= 1'b1;
          tx_data_q <= hex_char(hold_q[3:0]);
          state_q   <= ST_WAIT_LO;
        end
        ST_WAIT_LO: begin
          if (i_tx_done) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_tx_data_ready = tx_rdy_q;
  assign o_tx_data       = tx_data_q;
  assign o_last_byte     = last_q;
  assign o_count         = count_q;
  assign o_fill          = fill_q;
  assign o_empty         = empty_q;
  assign o_full          = full_q;
  assign o_overflow      = ovf_q;

endmodule

// File: tb/tb_uart_echo_fifo.sv
`timescale 1ns/1ps
// Bench for uart_echo_fifo: three instances (raw/DEPTH 4, uppercase/DEPTH 16,
// hex/DEPTH 8 with an 8-bit counter) share one stimulus stream. A queue-level
// reference model is compared against every instance after each clock edge,
// and directed sequences check the documented corner cases.
module tb_uart_echo_fifo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_v = 1'b0;
  logic [7:0] rx_d = 8'h00;
  logic       tx_done = 1'b0;
  logic       clr = 1'b0;

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic       r0, r1, r2;
  logic [7:0] d0, d1, d2, l0, l1, l2;
  logic [15:0] c0, c1;
  logic [7:0] c2;
  logic [2:0] f0;
  logic [4:0] f1;
  logic [3:0] f2;
  logic       e0, e1, e2, u0, u1, u2, ov0, ov1, ov2;

  uart_echo_fifo #(.DEPTH(4), .ADDR_W(2), .MODE(0), .CNT_W(16)) dut0 (
    .i_clk(clk), .i_reset(rst_n), .i_rx_data_ready(rx_v), .i_rx_data(rx_d),
    .i_tx_done(tx_done), .i_clr_ovf(clr), .o_tx_data_ready(r0), .o_tx_data(d0),
    .o_last_byte(l0), .o_count(c0), .o_fill(f0), .o_empty(e0), .o_full(u0),
    .o_overflow(ov0));

  uart_echo_fifo #(.DEPTH(16), .ADDR_W(4), .MODE(1), .CNT_W(16)) dut1 (
    .i_clk(clk), .i_reset(rst_n), .i_rx_data_ready(rx_v), .i_rx_data(rx_d),
    .i_tx_done(tx_done), .i_clr_ovf(clr), .o_tx_data_ready(r1), .o_tx_data(d1),
    .o_last_byte(l1), .o_count(c1), .o_fill(f1), .o_empty(e1), .o_full(u1),
    .o_overflow(ov1));

  uart_echo_fifo #(.DEPTH(8), .ADDR_W(3), .MODE(2), .CNT_W(8)) dut2 (
    .i_clk(clk), .i_reset(rst_n), .i_rx_data_ready(rx_v), .i_rx_data(rx_d),
    .i_tx_done(tx_done), .i_clr_ovf(clr), .o_tx_data_ready(r2), .o_tx_data(d2),
    .o_last_byte(l2), .o_count(c2), .o_fill(f2), .o_empty(e2), .o_full(u2),
    .o_overflow(ov2));

  // ---------------------------------------------------------------------------
  // Reference model: byte queue, list of characters still owed for the byte
  // being echoed, and a phase (0 = free, 1 = strobe due, 2 = awaiting done).
  // ---------------------------------------------------------------------------
  string      hx = "0123456789ABCDEF";
  int         mdepth [3] = '{4, 16, 8};
  int         mmode  [3] = '{0, 1, 2};
  int         mcmask [3] = '{65535, 65535, 255};
  logic [7:0] mf   [3][256];
  int         mn   [3];
  int         mph  [3];
  logic [7:0] pend [3][2];
  int         np   [3];
  int         pi   [3];
  logic       mrdy [3];
  logic [7:0] mtx  [3];
  logic [7:0] mlast[3];
  int         mcnt [3];
  logic       movf [3];

  task automatic model_reset(input int d);
    mn[d] = 0; mph[d] = 0; np[d] = 0; pi[d] = 0;
    mrdy[d] = 1'b0; mtx[d] = 8'h00; mlast[d] = 8'h00; mcnt[d] = 0; movf[d] = 1'b0;
  endtask

  task automatic model_step(input int d);
    logic pop, wr;
    logic [7:0] b;
    pop = (mph[d] == 0) && (mn[d] > 0);
    wr  = rx_v && ((mn[d] < mdepth[d]) || pop);
    mrdy[d] = 1'b0;
    if (mph[d] == 0) begin
      if (pop) begin
        b = mf[d][0];
        for (int i = 0; i < 255; i++) mf[d][i] = mf[d][i+1];
        mn[d]--;
        np[d] = 1; pi[d] = 0;
        if (mmode[d] == 1) pend[d][0] = (b >= 8'h61 && b <= 8'h7A) ? b - 8'h20 : b;
        else if (mmode[d] == 2) begin
          pend[d][0] = hx[b[7:4]];
          pend[d][1] = hx[b[3:0]];
          np[d] = 2;
        end else pend[d][0] = b;
        mph[d] = 1;
      end
    end else if (mph[d] == 1) begin
      mrdy[d] = 1'b1;
      mtx[d]  = pend[d][pi[d]];
      pi[d]++;
      mph[d]  = 2;
    end else if (tx_done) begin
      mph[d] = (pi[d] < np[d]) ? 1 : 0;
    end
    if (wr) begin
      mf[d][mn[d]] = rx_d;
      mn[d]++;
      mlast[d] = rx_d;
      mcnt[d]  = (mcnt[d] + 1) & mcmask[d];
    end
    if (rx_v && !wr) movf[d] = 1'b1;
    else if (clr)    movf[d] = 1'b0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) for (int d = 0; d < 3; d++) model_reset(d);
    else        for (int d = 0; d < 3; d++) model_step(d);
  end

  // Strobe monitor and per-edge model comparison.
  int         ns [3] = '{0, 0, 0};
  logic [7:0] sq0[$];

  function automatic logic [43:0] exp_vec(input int d);
    return {mrdy[d], mtx[d], mlast[d], 16'(mcnt[d]), 8'(mn[d]),
            (mn[d] == 0), (mn[d] == mdepth[d]), movf[d]};
  endfunction

  always @(posedge clk) begin
    logic [43:0] act [3];
    #1;
    act[0] = {r0, d0, l0, c0, 5'b0, f0, e0, u0, ov0};
    act[1] = {r1, d1, l1, c1, 3'b0, f1, e1, u1, ov1};
    act[2] = {r2, d2, l2, 8'b0, c2, 4'b0, f2, e2, u2, ov2};
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (act[d] !== exp_vec(d)) begin
        errors++;
        $display("FAIL model_dut%0d t=%0t got %h expected %h", d, $time, act[d], exp_vec(d));
      end
    end
    if (r0) begin ns[0]++; sq0.push_back(d0); end
    if (r1) ns[1]++;
    if (r2) ns[2]++;
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_done();
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
  endtask

  task automatic push(input logic [7:0] b);
    rx_v = 1'b1; rx_d = b;
    @(negedge clk);
    rx_v = 1'b0;
  endtask

  task automatic drain(input int n);
    repeat (n) begin
      pulse_done();
      cyc(3);
    end
  endtask

  typedef struct {
    logic [7:0] in_b;
    logic [7:0] up;
    logic [7:0] hi;
    logic [7:0] lo;
  } vec_t;

  vec_t tbl [8];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, b1, b2, k;

    tbl[0] = '{8'h61, 8'h41, 8'h36, 8'h31};
    tbl[1] = '{8'h7A, 8'h5A, 8'h37, 8'h41};
    tbl[2] = '{8'h5B, 8'h5B, 8'h35, 8'h42};
    tbl[3] = '{8'h7B, 8'h7B, 8'h37, 8'h42};
    tbl[4] = '{8'h60, 8'h60, 8'h36, 8'h30};
    tbl[5] = '{8'hA7, 8'hA7, 8'h41, 8'h37};
    tbl[6] = '{8'h00, 8'h00, 8'h30, 8'h30};
    tbl[7] = '{8'hFF, 8'hFF, 8'h46, 8'h46};

    // Reset values
    cyc(2);
    chk("rst_rdy",   r0, 0);  chk("rst_tx",    d0, 8'h00);
    chk("rst_last",  l0, 8'h00); chk("rst_count", c0, 0);
    chk("rst_fill",  f0, 0);  chk("rst_empty", e0, 1);
    chk("rst_full",  u0, 0);  chk("rst_ovf",   ov0, 0);
    chk("rst_empty1", e1, 1); chk("rst_empty2", e2, 1);
    rst_n = 1'b1;
    cyc(2);

    // Single byte, raw echo latency
    rx_v = 1'b1; rx_d = 8'h41;
    after_edge();
    rx_v = 1'b0;
    chk("single_rdy_t0", r0, 0); chk("single_fill_t0", f0, 1);
    chk("single_last", l0, 8'h41); chk("single_count", c0, 1);
    after_edge();
    chk("single_rdy_t1", r0, 0); chk("single_empty_t1", e0, 1);
    after_edge();
    chk("single_rdy_t2", r0, 1); chk("single_tx", d0, 8'h41);
    chk("single_tx_m1", d1, 8'h41); chk("single_rdy_m2", r2, 1);
    chk("single_tx_m2", d2, 8'h34);
    after_edge();
    chk("single_rdy_t3", r0, 0); chk("single_tx_hold", d0, 8'h41);
    @(negedge clk);
    drain(12);

    // Burst into DEPTH 4 with the transmitter stalled
    sq0.delete();
    for (int i = 0; i < 6; i++) begin
      rx_v = 1'b1; rx_d = 8'(8'h31 + i);
      @(negedge clk);
    end
    rx_v = 1'b0;
    chk("burst_fill", f0, 4);    chk("burst_full", u0, 1);
    chk("burst_ovf", ov0, 1);    chk("burst_count", c0, 6);
    chk("burst_last", l0, 8'h35); chk("burst_ovf_d8", ov2, 0);
    chk("burst_count_d8", c2, 7);
    cyc(50);
    chk("burst_one_strobe", sq0.size(), 1);
    drain(24);
    chk("burst_nchars", sq0.size(), 5);
    for (int i = 0; i < 5 && i < sq0.size(); i++)
      chk("burst_order", sq0[i], 8'(8'h31 + i));
    chk("burst_ovf_sticky", ov0, 1);
    clr = 1'b1; @(negedge clk); clr = 1'b0;
    chk("burst_ovf_clr", ov0, 0);

    // Push on the edge the FSM pops while full
    sq0.delete();
    for (int i = 0; i < 5; i++) begin
      rx_v = 1'b1; rx_d = 8'(8'h50 + i);
      @(negedge clk);
    end
    rx_v = 1'b0;
    cyc(4);
    chk("simul_pre_fill", f0, 4); chk("simul_pre_ovf", ov0, 0);
    tx_done = 1'b1; @(negedge clk);
    tx_done = 1'b0; rx_v = 1'b1; rx_d = 8'h55; @(negedge clk);
    rx_v = 1'b0;
    chk("simul_fill", f0, 4);  chk("simul_full", u0, 1);
    chk("simul_ovf", ov0, 0);  chk("simul_last", l0, 8'h55);
    chk("simul_count", c0, 12);
    drain(24);
    chk("simul_nchars", sq0.size(), 6);
    for (int i = 0; i < 6 && i < sq0.size(); i++)
      chk("simul_order", sq0[i], 8'(8'h50 + i));

    // Table: raw / uppercase / hex transforms
    foreach (tbl[i]) begin
      b0 = ns[0]; b1 = ns[1]; b2 = ns[2];
      push(tbl[i].in_b);
      k = 0;
      while (!r1 && k < 10) begin after_edge(); k++; end
      chk("tbl_strobe", r1, 1);
      chk("tbl_raw", d0, tbl[i].in_b);
      chk("tbl_upper", d1, tbl[i].up);
      chk("tbl_hex_hi", d2, tbl[i].hi);
      cyc(5);
      chk("tbl_hex_waits", ns[2], b2 + 1);
      pulse_done();
      k = 0;
      while (!r2 && k < 10) begin after_edge(); k++; end
      chk("tbl_lo_strobe", r2, 1);
      chk("tbl_hex_lo", d2, tbl[i].lo);
      @(negedge clk);
      pulse_done();
      cyc(2);
      pulse_done();
      pulse_done();
      cyc(5);
      chk("tbl_n_raw", ns[0], b0 + 1);
      chk("tbl_n_upper", ns[1], b1 + 1);
      chk("tbl_n_hex", ns[2], b2 + 2);
    end

    // Randomised traffic, checked by the model on every edge
    repeat (3000) begin
      rx_v    = ($urandom_range(99) < 35);
      rx_d    = 8'($urandom);
      tx_done = ($urandom_range(99) < 20);
      clr     = ($urandom_range(99) < 3);
      @(negedge clk);
    end
    rx_v = 1'b0; tx_done = 1'b0; clr = 1'b0;
    drain(80);

    // Asynchronous reset in the middle of a transmission
    for (int i = 0; i < 5; i++) begin
      rx_v = 1'b1; rx_d = 8'(8'h70 + i);
      @(negedge clk);
    end
    rx_v = 1'b0;
    cyc(3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rdy", r0, 0);   chk("arst_tx", d0, 8'h00);
    chk("arst_last", l0, 8'h00); chk("arst_count", c0, 0);
    chk("arst_fill", f0, 0);  chk("arst_empty", e0, 1);
    chk("arst_full", u0, 0);  chk("arst_ovf", ov0, 0);
    chk("arst_fill_d16", f1, 0); chk("arst_fill_d8", f2, 0);
    chk("arst_count_d8", c2, 0);
    @(negedge clk);
    rst_n = 1'b1;
    b0 = ns[0]; b1 = ns[1]; b2 = ns[2];
    drain(10);
    chk("arst_no_strobe0", ns[0], b0);
    chk("arst_no_strobe1", ns[1], b1);
    chk("arst_no_strobe2", ns[2], b2);
    chk("arst_post_empty", e0, 1);
    chk("arst_post_count", c0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_echo_fifo.md
Name: uart_echo_fifo

Overview:
- Parametrised buffering echo engine between the UART receiver's byte strobe and the UART transmitter's load strobe in the loopback top.
- Replaces the direct RX-to-TX wiring. Back-to-back received bytes queue in a FIFO instead of being lost while the transmitter is busy.
- Adds selectable echo transforms and a received-byte counter.
- Keeps a last-byte register for the seven-segment digits, plus overflow and fill status.

Parameters:
- DEPTH, 16, FIFO entries; power of two, 2..256.
- ADDR_W, 4, log2(DEPTH); must match DEPTH.
- MODE, 0, echo mode. 0 = raw echo. 1 = ASCII lowercase a-z folded to uppercase. 2 = hex echo: each byte sent as two ASCII hex characters, upper nibble first, digits 0-9/A-F.
- CNT_W, 16, width of the received-byte counter.

Ports:
- i_clk  in  1  system clock; all state changes on the rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_rx_data_ready  in  1  one-cycle strobe from the receiver: i_rx_data is valid.
- i_rx_data  in  8  received byte.
- i_tx_done  in  1  one-cycle strobe from the transmitter: current character's stop bit is finished.
- i_clr_ovf  in  1  synchronous clear of o_overflow.
- o_tx_data_ready  out  1  one-cycle load strobe to the transmitter.
- o_tx_data  out  8  character for the transmitter; held from the strobe until the next strobe.
- o_last_byte  out  8  last byte accepted into the FIFO; drives the display digits.
- o_count  out  CNT_W  bytes accepted since reset; wraps 2^CNT_W-1 -> 0.
- o_fill  out  ADDR_W+1  current FIFO occupancy, 0..DEPTH.
- o_empty  out  1  o_fill == 0.
- o_full  out  1  o_fill == DEPTH.
- o_overflow  out  1  sticky: a byte was dropped because the FIFO was full.

Behaviour:
- Reset (i_reset low, asynchronous): pointers and o_fill = 0, o_empty = 1, o_full = 0, o_overflow = 0, o_tx_data_ready = 0, o_tx_data = 0x00, o_last_byte = 0x00, o_count = 0, FSM = IDLE. Reset mid-transmission discards the FIFO contents and any pending second hex character. Release is synchronous in effect: the first active edge is the one after deassertion.
- Push:
  - An edge with i_rx_data_ready = 1 and (not full, or a pop on the same edge) writes i_rx_data.
  - On a write: o_last_byte <= i_rx_data, o_count += 1.
  - If full and no pop on that edge: the byte is dropped, o_overflow <= 1, and o_count and o_last_byte are unchanged.
- Pop: occurs on the edge where the FSM leaves IDLE. A simultaneous push and pop leaves o_fill unchanged.
- o_overflow: cleared by i_clr_ovf = 1. If set and clear coincide, set wins.
- FSM states: IDLE, SEND, WAIT, SEND_LO, WAIT_LO.
  - IDLE: if not empty, pop the head into a holding register and go to SEND.
  - SEND: o_tx_data_ready = 1 for exactly this cycle. o_tx_data carries the character. Next state is WAIT.
  - WAIT: hold until i_tx_done = 1. Then go to SEND_LO if MODE = 2, otherwise go to IDLE.
  - SEND_LO (MODE 2 only): strobe the lower-nibble character for one cycle, then go to WAIT_LO.
  - WAIT_LO: on i_tx_done, go to IDLE.
  - An i_tx_done seen in IDLE, SEND or SEND_LO is ignored.
- Transforms:
  - MODE 1: bytes 0x61..0x7A have 0x20 subtracted; all other bytes pass unchanged.
  - MODE 2: nibble n -> 0x30+n for n <= 9, 0x37+n for n >= 10.
- Latency: with an empty FIFO and FSM in IDLE, a push on edge t gives o_tx_data_ready high during the cycle after edge t+2, i.e. 2 cycles of latency. Minimum spacing between consecutive characters is 3 cycles plus the transmitter time.
- o_fill, o_empty and o_full are registered and reflect the state after each edge.

Test Plan:
- Reset mid-burst: load 5 bytes, assert i_reset low mid-WAIT -> all outputs at reset values immediately (asynchronous), no further strobes after release.
- MODE 0, single byte: push 0x41 -> one o_tx_data_ready pulse 2 cycles later with o_tx_data = 0x41; o_last_byte = 0x41; o_count = 1; o_empty = 1 after the pop.
- MODE 0 burst, DEPTH = 4, i_tx_done delayed 50 cycles: push 0x31, 0x32, 0x33, 0x34, 0x35, 0x36 on consecutive strobes.
  - Five bytes are accepted: 0x31 is popped, then the FIFO fills to 4.
  - 0x36 is dropped and o_overflow = 1; o_count = 5; o_last_byte = 0x35.
  - Output order is 0x31..0x35; i_clr_ovf clears the flag.
- Simultaneous push and pop while full: push on the same edge the FSM pops -> byte accepted, o_fill stays 4, o_overflow stays 0.
- MODE 1: push 0x61, 0x7A, 0x5B, 0x7B -> sent 0x41, 0x5A, 0x5B, 0x7B.
- MODE 2: push 0xA7 -> exactly two strobes, 0x41 then 0x37, the second only after the first i_tx_done; i_tx_done pulsed in IDLE produces no strobe.
